serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Multi-cycle, parametrised adder/subtractor built around a registered full-adder carry.
//  Consumes DIGIT bits per clock, LSB first, until a WIDTH-bit result is complete.
//  Uses a start/busy/done handshake. Reports carry-out and signed overflow.
//  Serves as the area-lean arithmetic unit for datapaths where latency is acceptable.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 2
//  DIGIT  1  bits processed per cycle; must divide WIDTH exactly (N = WIDTH/DIGIT cycles)
// PORTS
//  clk     in   1      single clock; all state updates on the rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only when not busy
//  sub     in   1      0 = a+b, 1 = a-b; sampled together with start
//  a       in   WIDTH  operand A; sampled together with start
//  b       in   WIDTH  operand B; sampled together with start
//  busy    out  1      high while digits are being processed
//  done    out  1      one-cycle pulse: result/cout/ovf have just been updated
//  result  out  WIDTH  sum/difference modulo 2^WIDTH; held until the next completion
//  cout    out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf     out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; busy, done, result, cout, ovf, carry, counter all 0.
//    Reset in RUN aborts the operation: no done pulse, and result is cleared.
//  - FSM states are IDLE, RUN and DONE. busy = (state==RUN); done = (state==DONE).
//  - IDLE or DONE with start=1 at an edge:
//    - latch opA=a and opB = sub ? ~b : b
//    - set carry=sub and count=0
//    - latch sa=a[MSB] and sb=opB[MSB]
//    - go to RUN
//  - DONE with start=0 -> IDLE. IDLE with start=0 stays in IDLE.
//  - RUN, each edge:
//    - {c, s} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry
//    - shift opA and opB right by DIGIT
//    - shift s into the top DIGIT bits of the partial-result register
//    - carry = c; count++
//  - RUN at the edge where count==N-1:
//    - commit the final digit
//    - result = full partial register, cout = final c
//    - ovf = (sa==sb) && (result[MSB]!=sa)
//    - go to DONE
//  - Latency: start sampled at edge E0 -> busy high for exactly N cycles (E0+1..E0+N).
//    done is high in the cycle after E0+N.
//  - Back-to-back: start during DONE is accepted, so throughput is one op per N+1 cycles.
//  - start while busy is ignored; a, b and sub may change freely while busy.
//  - result, cout and ovf change only at the completing edge or on reset.
//    They are stable while busy and through IDLE.
//  - Widths: the internal adder is DIGIT+1 bits wide. No other arithmetic exceeds WIDTH.
//    count is $clog2(N)+1 bits.
//  - WIDTH==DIGIT (N=1): busy is high for 1 cycle and done follows, with the same rules.
// TESTING (WIDTH=8, DIGIT=1 unless noted)
//  1. a=7F b=01 sub=0 start 1 cycle -> busy 8 cycles, then done 1 cycle;
//     result=80 cout=0 ovf=1.
//  2. a=FF b=01 sub=0 -> result=00 cout=1 ovf=0.
//     a=05 b=07 sub=1 -> result=FE cout=0 ovf=0.
//  3. a=80 b=01 sub=1 -> result=7F cout=1 ovf=1.
//     a=00 b=00 sub=1 -> result=00 cout=1 ovf=0.
//  4. start at cycle 3 of a busy op, with different a/b -> ignored;
//     the first result is unchanged and no extra done appears.
//     start held high in DONE -> the second op begins; done pulses every 9 cycles.
//  5. rst asserted mid-RUN (cycle 4), asynchronously between edges
//     -> busy/done/result go 0 immediately; no done after release; next op is correct.
//  6. DIGIT=4: a=9C b=A5 sub=0 -> busy 2 cycles; result=41 cout=1 ovf=1.
//     Random self-check of 1000 ops vs a+b / a-b across WIDTH=16, DIGIT in {1,2,4,16}.

Source files
------------

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor with a registered carry.
// Operands are latched on start and consumed DIGIT bits per clock, LSB first.
// Subtraction is a + ~b + 1, so the carry register is seeded with sub.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one digit added per clock, busy high
// DONE  | result/cout/ovf just committed; start is accepted again
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] part_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             sa_q;
    logic             sb_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT:0]   dsum_d;
    logic [WIDTH-1:0] part_d;
    logic [WIDTH-1:0] op_b_in_d;

    // One-digit adder and the partial register after shifting the new digit in at the top.
    always_comb begin
        dsum_d    = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        part_d    = (part_q >> DIGIT) | (WIDTH'(dsum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
        op_b_in_d = sub ? ~b : b;
    end

    // Control FSM and datapath registers; busy/done are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            part_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= op_b_in_d;
                        part_q  <= '0;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        sa_q    <= a[WIDTH-1];
                        sb_q    <= op_b_in_d[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    op_a_q  <= op_a_q >> DIGIT;
                    op_b_q  <= op_b_q >> DIGIT;
                    part_q  <= part_d;
                    carry_q <= dsum_d[DIGIT];
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        result_q <= part_d;
                        cout_q   <= dsum_d[DIGIT];
                        ovf_q    <= (sa_q == sb_q) && (part_d[WIDTH-1] != sa_q);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub: directed cases on WIDTH=8/DIGIT=1 and DIGIT=4,
// plus random operations on WIDTH=16 with DIGIT in {1,2,4,16} against an arithmetic model.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // WIDTH=8, DIGIT=1
    logic       s8_start = 0, s8_sub = 0;
    logic [7:0] s8_a = 0, s8_b = 0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] res8;

    // WIDTH=8, DIGIT=4
    logic       p_start = 0, p_sub = 0;
    logic [7:0] p_a = 0, p_b = 0;
    logic       busy84, done84, cout84, ovf84;
    logic [7:0] res84;

    // WIDTH=16, DIGIT = 1,2,4,16 sharing one set of inputs
    logic        st16 = 0, sub16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16 [4];
    logic        done16 [4];
    logic        cout16 [4];
    logic        ovf16  [4];
    logic [15:0] res16  [4];
    localparam int NCYC16 [4] = '{16, 8, 4, 1};

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub), .a(s8_a), .b(s8_b),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8));

    serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut84 (
        .clk(clk), .rst(rst), .start(p_start), .sub(p_sub), .a(p_a), .b(p_b),
        .busy(busy84), .done(done84), .result(res84), .cout(cout84), .ovf(ovf84));

    serial_add_sub #(.WIDTH(16), .DIGIT(1)) dut16_1 (
        .clk(clk), .rst(rst), .start(st16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16[0]), .done(done16[0]), .result(res16[0]), .cout(cout16[0]), .ovf(ovf16[0]));
    serial_add_sub #(.WIDTH(16), .DIGIT(2)) dut16_2 (
        .clk(clk), .rst(rst), .start(st16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16[1]), .done(done16[1]), .result(res16[1]), .cout(cout16[1]), .ovf(ovf16[1]));
    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16_4 (
        .clk(clk), .rst(rst), .start(st16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16[2]), .done(done16[2]), .result(res16[2]), .cout(cout16[2]), .ovf(ovf16[2]));
    serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut16_16 (
        .clk(clk), .rst(rst), .start(st16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16[3]), .done(done16[3]), .result(res16[3]), .cout(cout16[3]), .ovf(ovf16[3]));

    // Reference: unsigned/signed integer arithmetic, result reduced modulo 2^w.
    function automatic void model(input int w, input longint ua, input longint ub, input bit s,
                                  output longint res, output bit co, output bit ov);
        longint m, sa, sb, raw, sr;
        m   = longint'(1) << w;
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            raw = ua - ub;
            co  = (ua >= ub);
            sr  = sa - sb;
        end else begin
            raw = ua + ub;
            co  = (raw >= m);
            sr  = sa + sb;
        end
        res = ((raw % m) + m) % m;
        ov  = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                           input string name);
        longint er; bit ec, eo;
        logic [7:0] prev;
        int nb = 0, t = 0;
        bit unstable = 0;
        model(8, longint'(ta), longint'(tb), ts, er, ec, eo);
        prev = res8;
        s8_a = ta; s8_b = tb; s8_sub = ts; s8_start = 1;
        tick();
        s8_start = 0;
        while (!done8 && t < 20) begin
            if (busy8) nb++;
            if (res8 !== prev) unstable = 1;
            tick();
            t++;
        end
        n_tests++;
        if (done8 !== 1'b1) begin
            n_fail++; $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", name, done8, t);
        end
        n_tests++;
        if (nb != 8 || unstable) begin
            n_fail++; $display("FAIL %s busy_len: busy=%0d unstable=%0d, required 8/0", name, nb, unstable);
        end
        n_tests++;
        if ({res8, cout8, ovf8} !== {er[7:0], ec, eo}) begin
            n_fail++; $display("FAIL %s result: got %h c=%b v=%b, required %h c=%b v=%b",
                               name, res8, cout8, ovf8, er[7:0], ec, eo);
        end
        tick();
        n_tests++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || res8 !== er[7:0]) begin
            n_fail++; $display("FAIL %s after_done: done=%b busy=%b res=%h, required 0/0/%h",
                               name, done8, busy8, res8, er[7:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        #12;
        n_tests++;
        if ({busy8, done8, res8, cout8, ovf8} !== '0 || {busy84, done84, res84} !== '0 ||
            res16[0] !== 16'h0 || res16[3] !== 16'h0) begin
            n_fail++; $display("FAIL reset_state: busy=%b done=%b res=%h c=%b v=%b res84=%h, required zeros",
                               busy8, done8, res8, cout8, ovf8, res84);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_vectors();
        run_op8(8'h7F, 8'h01, 1'b0, "7F+01");
        run_op8(8'hFF, 8'h01, 1'b0, "FF+01");
        run_op8(8'h05, 8'h07, 1'b1, "05-07");
        run_op8(8'h80, 8'h01, 1'b1, "80-01");
        run_op8(8'h00, 8'h00, 1'b1, "00-00");
    endtask

    task automatic test_ignore_start();
        int t = 0, extra = 0;
        s8_a = 8'h12; s8_b = 8'h34; s8_sub = 0; s8_start = 1;
        tick();
        s8_start = 0;
        tick(); tick();
        s8_a = 8'h55; s8_b = 8'h66; s8_sub = 1; s8_start = 1;
        tick();
        s8_start = 0;
        while (!done8 && t < 20) begin tick(); t++; end
        n_tests++;
        if (done8 !== 1'b1 || res8 !== 8'h46) begin
            n_fail++; $display("FAIL ignore_start: done=%b res=%h, required 1/46", done8, res8);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8 || busy8) extra++;
        end
        n_tests++;
        if (extra != 0 || res8 !== 8'h46) begin
            n_fail++; $display("FAIL ignore_extra: extra=%0d res=%h, required 0/46", extra, res8);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        logic [7:0] r1 = 0, r2 = 0;
        s8_a = 8'h10; s8_b = 8'h20; s8_sub = 0; s8_start = 1;
        tick();
        s8_a = 8'h30; s8_b = 8'h05; s8_sub = 1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done8 === 1'b1) begin
                if (d1 < 0) begin d1 = c; r1 = res8; end
                else if (d2 < 0) begin d2 = c; r2 = res8; end
            end
        end
        s8_start = 0;
        n_tests++;
        if (d1 != 8 || d2 - d1 != 9) begin
            n_fail++; $display("FAIL b2b_timing: first=%0d gap=%0d, required 8/9", d1, d2 - d1);
        end
        n_tests++;
        if (r1 !== 8'h30 || r2 !== 8'h2B) begin
            n_fail++; $display("FAIL b2b_results: %h %h, required 30 2B", r1, r2);
        end
        for (int i = 0; i < 30; i++) begin
            if (!busy8 && !done8) break;
            tick();
        end
        n_tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: busy=%b done=%b, required 0/0", busy8, done8);
        end
    endtask

    task automatic test_async_reset();
        int extra = 0;
        s8_a = 8'h3C; s8_b = 8'h11; s8_sub = 0; s8_start = 1;
        tick();
        s8_start = 0;
        tick(); tick(); tick();
        #2 rst = 1;
        #1;
        n_tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'h00) begin
            n_fail++; $display("FAIL async_reset: busy=%b done=%b res=%h, required 0/0/00", busy8, done8, res8);
        end
        #1 rst = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++; $display("FAIL reset_no_done: activity=%0d, required 0", extra);
        end
        run_op8(8'h3C, 8'h11, 1'b0, "post_reset");
    endtask

    task automatic test_digit4();
        int nb = 0, t = 0;
        p_a = 8'h9C; p_b = 8'hA5; p_sub = 0; p_start = 1;
        tick();
        p_start = 0;
        while (!done84 && t < 10) begin
            if (busy84) nb++;
            tick();
            t++;
        end
        n_tests++;
        if (done84 !== 1'b1 || nb != 2) begin
            n_fail++; $display("FAIL digit4_timing: done=%b busy=%0d, required 1/2", done84, nb);
        end
        n_tests++;
        if ({res84, cout84, ovf84} !== {8'h41, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL digit4_result: %h c=%b v=%b, required 41 c=1 v=1", res84, cout84, ovf84);
        end
        tick();
    endtask

    task automatic test_random8();
        for (int i = 0; i < 40; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
        end
    endtask

    task automatic test_random16();
        longint er; bit ec, eo;
        bit seen [4];
        for (int it = 0; it < 250; it++) begin
            case (it)
                0:       begin a16 = 16'h7FFF; b16 = 16'h0001; sub16 = 0; end
                1:       begin a16 = 16'h8000; b16 = 16'h0001; sub16 = 1; end
                2:       begin a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 0; end
                3:       begin a16 = 16'h0000; b16 = 16'h8000; sub16 = 1; end
                default: begin a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); end
            endcase
            model(16, longint'(a16), longint'(b16), sub16, er, ec, eo);
            st16 = 1;
            tick();
            st16 = 0;
            a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
            for (int k = 0; k < 4; k++) seen[k] = 0;
            for (int t = 0; t <= 20; t++) begin
                for (int k = 0; k < 4; k++) begin
                    if (!seen[k] && done16[k] === 1'b1) begin
                        seen[k] = 1;
                        n_tests++;
                        if (t != NCYC16[k] || {res16[k], cout16[k], ovf16[k]} !== {er[15:0], ec, eo}) begin
                            n_fail++;
                            $display("FAIL rand16[%0d] it=%0d: t=%0d res=%h c=%b v=%b, required t=%0d %h c=%b v=%b",
                                     k, it, t, res16[k], cout16[k], ovf16[k], NCYC16[k], er[15:0], ec, eo);
                        end
                    end
                end
                if (seen[0] && seen[1] && seen[2] && seen[3]) break;
                tick();
            end
            for (int k = 0; k < 4; k++) begin
                if (!seen[k]) begin
                    n_tests++; n_fail++;
                    $display("FAIL rand16[%0d] it=%0d: done=0 after 20 cycles, required 1", k, it);
                end
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_digit4();
        test_random8();
        test_random16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
